path_buffer: RTL and testbench

Parametrised direction-path store for the maze-solver datapath. Accepts direction codes one per cycle and supports stack-style backtracking (pop/undo of the newest entry). On request it replays the stored path over a valid/ready stream, either oldest-first (forward) or newest-first (reverse). Contents survive replay, so the same path can be replayed repeatedly; occupancy, full/empty and sticky overflow status are reported.

---
 rtl/path_buf_pkg.sv | 21 ++
 rtl/path_buf_mem.sv | 33 +++
 rtl/path_buffer.sv | 175 +++++++++++++++++
 tb/tb_path_buffer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/path_buf_pkg.sv
// Shared types for the maze-solver path buffer: direction codes, replay FSM
// states and replay-order constants.
package path_buf_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_DOWN  = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REPLAY = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic REPLAY_FWD = 1'b0;
    localparam logic REPLAY_REV = 1'b1;

endpackage

// File: rtl/path_buf_mem.sv
// Path entry storage: DEPTH x WIDTH register array with one synchronous write
// port and two asynchronous read ports (replay pointer and stack top).
module path_buf_mem
    import path_buf_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    input  logic [AW-1:0]    top_addr,
    output logic [WIDTH-1:0] top_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset; validity is tracked by count, so resetting
    // it would only add a wide reset network for no functional gain.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data  = mem[rd_addr];
    assign top_data = mem[top_addr];

endmodule

// File: rtl/path_buffer.sv
// Direction-path stack with backtracking and forward/reverse valid/ready
// replay. Define PATH_BUF_CANCEL_EN to turn an immediate reversal push into a pop.
module path_buffer
    import path_buf_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    input  logic             replay_start,
    input  logic             replay_rev,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             replay_done,
    output logic             busy,
    output logic [AW:0]      count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic [WIDTH-1:0] top
);

    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    state_t           state, state_d;
    logic [AW:0]      count_d, count_m1;
    logic [AW-1:0]    ptr, ptr_d;
    logic             rev, rev_d;
    logic [WIDTH-1:0] dout_d;
    logic             dout_valid_d, overflow_d;
    logic             wr_en;
    logic [AW-1:0]    wr_addr, rd_addr;
    logic [WIDTH-1:0] rd_data, top_data;
    logic             cancel;

    assign count_m1 = count - CNT_ONE;

    path_buf_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk      (clk),
        .we       (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (din),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .top_addr (count_m1[AW-1:0]),
        .top_data (top_data)
    );

    assign empty       = (count == '0);
    assign full        = (count == CNT_FULL);
    assign top         = empty ? '0 : top_data;
    assign replay_done = (state == DONE);
    assign busy        = (state != IDLE);

`ifdef PATH_BUF_CANCEL_EN
    // Stepping straight back the way we came undoes the previous move.
    assign cancel = push && !pop && !empty && (din == ~top);
`else
    assign cancel = 1'b0;
`endif

    // Replay read address: first entry when idle, next entry while replaying.
    always_comb begin
        if (state == IDLE) begin
            rd_addr = (replay_rev == REPLAY_REV) ? count_m1[AW-1:0] : '0;
        end else begin
            rd_addr = (rev == REPLAY_REV) ? ptr - PTR_ONE : ptr + PTR_ONE;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_d      = state;
        count_d      = count;
        ptr_d        = ptr;
        rev_d        = rev;
        dout_d       = dout;
        dout_valid_d = dout_valid;
        overflow_d   = overflow;
        wr_en        = 1'b0;
        wr_addr      = count[AW-1:0];

        if (clear) begin
            state_d      = IDLE;
            count_d      = '0;
            overflow_d   = 1'b0;
            dout_valid_d = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (replay_start) begin
                        if (!empty) begin
                            state_d      = REPLAY;
                            rev_d        = replay_rev;
                            ptr_d        = rd_addr;
                            dout_d       = rd_data;
                            dout_valid_d = 1'b1;
                        end else begin
                            state_d = DONE;
                        end
                    end else if (push && pop) begin
                        wr_en = 1'b1;
                        if (!empty) begin
                            wr_addr = count_m1[AW-1:0];
                        end else begin
                            count_d = count + CNT_ONE;
                        end
                    end else if (push) begin
                        if (cancel) begin
                            count_d = count_m1;
                        end else if (!full) begin
                            wr_en   = 1'b1;
                            count_d = count + CNT_ONE;
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end else if (pop && !empty) begin
                        count_d = count_m1;
                    end
                end
                REPLAY: begin
                    if (dout_ready) begin
                        if ((rev == REPLAY_REV) ? (ptr == '0)
                                                : (ptr == count_m1[AW-1:0])) begin
                            dout_valid_d = 1'b0;
                            state_d      = DONE;
                        end else begin
                            ptr_d  = rd_addr;
                            dout_d = rd_data;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            ptr        <= '0;
            rev        <= REPLAY_FWD;
            dout       <= '0;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_d;
            count      <= count_d;
            ptr        <= ptr_d;
            rev        <= rev_d;
            dout       <= dout_d;
            dout_valid <= dout_valid_d;
            overflow   <= overflow_d;
        end
    end

endmodule

// File: tb/tb_path_buffer.sv
// Directed bench for path_buffer (DEPTH=8): table-driven stack ops plus
// hand-written replay, stall, overflow, clear and reset sequences.
module tb_path_buffer;
    import path_buf_pkg::*;

    localparam int WIDTH = 2;
    localparam int DEPTH = 8;
    localparam int AW    = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             rst;
    logic             clear, push, pop, replay_start, replay_rev, dout_ready;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout, top;
    logic             dout_valid, replay_done, busy, empty, full, overflow;
    logic [AW:0]      count;

    int checks = 0;
    int errors = 0;

    path_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .push         (push),
        .pop          (pop),
        .din          (din),
        .replay_start (replay_start),
        .replay_rev   (replay_rev),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .dout_ready   (dout_ready),
        .replay_done  (replay_done),
        .busy         (busy),
        .count        (count),
        .empty        (empty),
        .full         (full),
        .overflow     (overflow),
        .top          (top)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        push;
        logic        pop;
        logic [1:0]  din;
        logic [AW:0] cnt;
        logic [1:0]  top;
        logic        empty;
        logic        full;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic p, input logic q, input logic [1:0] d);
        push = p;
        pop  = q;
        din  = d;
        tick();
        push = 1'b0;
        pop  = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    logic [1:0] exp_fwd [4];
    logic [1:0] exp_rev [4];
    int         idx;
    logic       done_seen;

    initial begin
        vecs[0] = '{1'b0, 1'b1, DIR_UP,    4'd0, 2'b00, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 1'b0, DIR_RIGHT, 4'd1, 2'b01, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, DIR_LEFT,  4'd2, 2'b10, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b1, DIR_DOWN,  4'd2, 2'b11, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b1, DIR_UP,    4'd2, 2'b00, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b1, DIR_UP,    4'd1, 2'b01, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b1, DIR_UP,    4'd0, 2'b00, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 1'b1, DIR_LEFT,  4'd1, 2'b10, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 1'b0, DIR_UP,    4'd1, 2'b10, 1'b0, 1'b0};
        vecs[9] = '{1'b0, 1'b1, DIR_UP,    4'd0, 2'b00, 1'b1, 1'b0};
        exp_fwd[0] = 2'b00; exp_fwd[1] = 2'b01; exp_fwd[2] = 2'b10; exp_fwd[3] = 2'b11;
        exp_rev[0] = 2'b11; exp_rev[1] = 2'b10; exp_rev[2] = 2'b01; exp_rev[3] = 2'b00;

        rst = 1'b1; clear = 1'b0; push = 1'b0; pop = 1'b0; din = '0;
        replay_start = 1'b0; replay_rev = 1'b0; dout_ready = 1'b0;
        #2;
        check("rst dout",        32'(dout),        32'd0);
        check("rst dout_valid",  32'(dout_valid),  32'd0);
        check("rst replay_done", 32'(replay_done), 32'd0);
        check("rst busy",        32'(busy),        32'd0);
        check("rst count",       32'(count),       32'd0);
        check("rst empty",       32'(empty),       32'd1);
        check("rst full",        32'(full),        32'd0);
        check("rst overflow",    32'(overflow),    32'd0);
        check("rst top",         32'(top),         32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Stack operations from the table.
        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].push, vecs[i].pop, vecs[i].din);
            check($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].cnt));
            check($sformatf("vec%0d top", i),   32'(top),   32'(vecs[i].top));
            check($sformatf("vec%0d empty", i), 32'(empty), 32'(vecs[i].empty));
            check($sformatf("vec%0d full", i),  32'(full),  32'(vecs[i].full));
        end

        // Immediate reversal: cancels only when the feature is built in.
        do_op(1'b1, 1'b0, DIR_RIGHT);
        do_op(1'b1, 1'b0, DIR_LEFT);
`ifdef PATH_BUF_CANCEL_EN
        check("cancel count", 32'(count), 32'd0);
`else
        check("cancel count", 32'(count), 32'd2);
        check("cancel top",   32'(top),   32'(DIR_LEFT));
`endif
        do_clear();

        // Forward replay, ready high; push held during replay must be ignored.
        for (int i = 0; i < 4; i++) do_op(1'b1, 1'b0, exp_fwd[i]);
        check("fill count", 32'(count), 32'd4);
        dout_ready = 1'b1; replay_rev = REPLAY_FWD; replay_start = 1'b1;
        tick();
        replay_start = 1'b0;
        push = 1'b1; din = 2'b00;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("fwd beat%0d valid", i), 32'(dout_valid), 32'd1);
            check($sformatf("fwd beat%0d dout", i),  32'(dout),       32'(exp_fwd[i]));
            check($sformatf("fwd beat%0d busy", i),  32'(busy),       32'd1);
            tick();
        end
        push = 1'b0;
        check("fwd done pulse", 32'(replay_done), 32'd1);
        check("fwd done valid", 32'(dout_valid),  32'd0);
        check("fwd done busy",  32'(busy),        32'd1);
        tick();
        check("fwd done drop",  32'(replay_done), 32'd0);
        check("fwd idle busy",  32'(busy),        32'd0);
        check("fwd count kept", 32'(count),       32'd4);

        // Reverse replay with ready toggling 1,0,1,0,...
        dout_ready = 1'b0; replay_rev = REPLAY_REV; replay_start = 1'b1;
        tick();
        replay_start = 1'b0;
        idx = 0;
        done_seen = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (replay_done) begin
                done_seen = 1'b1;
                break;
            end
            if (dout_valid) begin
                if (idx < 4) check($sformatf("rev beat%0d dout", idx), 32'(dout), 32'(exp_rev[idx]));
                else         check("rev extra beat", 32'(dout_valid), 32'd0);
            end
            dout_ready = ~dout_ready;
            if (dout_valid && dout_ready) idx++;
            tick();
        end
        dout_ready = 1'b1;
        check("rev done seen",   32'(done_seen), 32'd1);
        check("rev beats",       32'(idx),       32'd4);
        check("rev valid at end", 32'(dout_valid), 32'd0);
        tick();
        check("rev count kept",  32'(count),     32'd4);
        do_clear();

        // Fill to capacity, overflow, replace-top when full, then clear.
        for (int i = 0; i < DEPTH; i++) do_op(1'b1, 1'b0, 2'(i));
        check("full flag",      32'(full),     32'd1);
        check("full count",     32'(count),    32'(DEPTH));
        check("full no ovf",    32'(overflow), 32'd0);
        do_op(1'b1, 1'b0, 2'b01);
        check("ovf set",        32'(overflow), 32'd1);
        check("ovf count",      32'(count),    32'(DEPTH));
        check("ovf top",        32'(top),      32'd3);
        do_op(1'b1, 1'b1, 2'b10);
        check("full replace top", 32'(top),    32'd2);
        check("full replace cnt", 32'(count),  32'(DEPTH));
        tick();
        check("ovf sticky",     32'(overflow), 32'd1);
        do_clear();
        check("clear count",    32'(count),    32'd0);
        check("clear ovf",      32'(overflow), 32'd0);
        check("clear empty",    32'(empty),    32'd1);

        // Clear in the middle of a replay aborts without a done pulse.
        do_op(1'b1, 1'b0, 2'b01);
        do_op(1'b1, 1'b0, 2'b11);
        replay_rev = REPLAY_FWD; replay_start = 1'b1;
        tick();
        replay_start = 1'b0;
        do_clear();
        check("clr replay valid", 32'(dout_valid),  32'd0);
        check("clr replay busy",  32'(busy),        32'd0);
        check("clr replay done",  32'(replay_done), 32'd0);
        tick();
        check("clr replay done2", 32'(replay_done), 32'd0);

        // Asynchronous reset in the middle of a replay.
        for (int i = 0; i < 3; i++) do_op(1'b1, 1'b0, 2'(i));
        replay_start = 1'b1;
        tick();
        replay_start = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check("midrst valid", 32'(dout_valid), 32'd0);
        check("midrst busy",  32'(busy),       32'd0);
        check("midrst count", 32'(count),      32'd0);
        #1;
        rst = 1'b0;
        tick();

        // Replay of an empty path: done pulse only.
        replay_start = 1'b1;
        tick();
        replay_start = 1'b0;
        check("empty replay done",  32'(replay_done), 32'd1);
        check("empty replay valid", 32'(dout_valid),  32'd0);
        check("empty replay busy",  32'(busy),        32'd1);
        tick();
        check("empty replay done2", 32'(replay_done), 32'd0);
        check("empty replay idle",  32'(busy),        32'd0);
        check("empty replay valid2", 32'(dout_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
